// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The state encoding doubles as the one-hot grant vector {m1,m0}.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the master that did not hold the bus last, no request picks IDLE.
module wshb_rr_pick
    import wshb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output arb_state_t pick_o
);

    always_comb begin
        pick_o = IDLE;
        case (req_i)
            2'b01:   pick_o = GNT0;
            2'b10:   pick_o = GNT1;
            2'b11:   pick_o = last_i ? GNT0 : GNT1;
            default: pick_o = IDLE;
        endcase
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter in front of the SDRAM controller.
// Round-robin with a per-tenure ack cap that only bites while the other master waits.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 16,
    parameter int SEL_W     = 2,
    parameter int MAX_BURST = 64
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic [DAT_W-1:0] m0_dat_ms,
    input  logic [2:0]       m0_cti,
    input  logic [1:0]       m0_bte,
    output logic             m0_ack,
    output logic [DAT_W-1:0] m0_dat_sm,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic [DAT_W-1:0] m1_dat_ms,
    input  logic [2:0]       m1_cti,
    input  logic [1:0]       m1_bte,
    output logic             m1_ack,
    output logic [DAT_W-1:0] m1_dat_sm,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [SEL_W-1:0] s_sel,
    output logic [DAT_W-1:0] s_dat_ms,
    output logic [2:0]       s_cti,
    output logic [1:0]       s_bte,
    input  logic             s_ack,
    input  logic [DAT_W-1:0] s_dat_sm,
    output logic [1:0]       gnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d, pick;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             own_cyc, oth_cyc, rel, pick_last;

    // On release the current owner becomes "last", so the picker hands a
    // waiting peer the bus directly, or re-grants the owner if it alone asks.
    assign pick_last = (state_q == IDLE) ? last_q : (state_q == GNT1);

    wshb_rr_pick u_pick (
        .req_i  ({m1_cyc, m0_cyc}),
        .last_i (pick_last),
        .pick_o (pick)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        own_cyc = (state_q == GNT1) ? m1_cyc : m0_cyc;
        oth_cyc = (state_q == GNT1) ? m0_cyc : m1_cyc;
        rel     = 1'b0;
        if (state_q == IDLE) begin
            state_d = pick;
        end else begin
            if (s_ack && cnt_q != CNT_W'(MAX_BURST))
                cnt_d = cnt_q + CNT_W'(1);
            // >= so a lone master that saturated the counter still yields
            // on its next ack once the peer shows up.
            rel = !own_cyc || (s_ack && oth_cyc && cnt_q >= CNT_W'(MAX_BURST - 1));
            if (rel) begin
                last_d  = (state_q == GNT1);
                cnt_d   = '0;
                state_d = pick;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_ms = '0;
        s_cti    = CTI_CLASSIC;
        s_bte    = BTE_LINEAR;
        case (state_q)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_ms = m0_dat_ms;
                s_cti    = m0_cti;
                s_bte    = m0_bte;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_ms = m1_dat_ms;
                s_cti    = m1_cti;
                s_bte    = m1_bte;
            end
            default: ;
        endcase
    end

    // An ack that lands while reset is asserted belongs to an aborted tenure.
    assign m0_ack    = (state_q == GNT0) && s_ack && !rst;
    assign m1_ack    = (state_q == GNT1) && s_ack && !rst;
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;
    assign gnt       = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: task-driven masters, a delay-programmable slave,
// and per-master scoreboards popped on every completed slave transfer.
module tb_wshb_arbiter;

    localparam int LIMIT = 2000;

    typedef struct packed {
        logic [31:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } ent_t;

    logic        CLK, rst;
    logic        m0_cyc, m0_stb, m0_we, m0_ack;
    logic [31:0] m0_adr;
    logic [1:0]  m0_sel, m0_bte;
    logic [15:0] m0_dat_ms, m0_dat_sm;
    logic [2:0]  m0_cti;
    logic        m1_cyc, m1_stb, m1_we, m1_ack;
    logic [31:0] m1_adr;
    logic [1:0]  m1_sel, m1_bte;
    logic [15:0] m1_dat_ms, m1_dat_sm;
    logic [2:0]  m1_cti;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr;
    logic [1:0]  s_sel, s_bte;
    logic [15:0] s_dat_ms, s_dat_sm;
    logic [2:0]  s_cti;
    logic [1:0]  gnt;

    int   n_vec, n_err, ack_cnt0, ack_cnt1, ack_delay, wait_cnt;
    logic ack_force;
    ent_t q0[$], q1[$];

    wshb_arbiter dut (
        .CLK(CLK), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_cti(m0_cti), .m0_bte(m0_bte),
        .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_cti(m1_cti), .m1_bte(m1_bte),
        .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_ms(s_dat_ms), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(gnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Slave: acks once stb has been held ack_delay cycles; read data tracks address.
    always @(posedge CLK) begin
        if (s_cyc && s_stb) wait_cnt <= s_ack ? 0 : wait_cnt + 1;
        else                wait_cnt <= 0;
    end
    assign s_ack    = ack_force | (s_cyc & s_stb & (wait_cnt >= ack_delay));
    assign s_dat_sm = s_adr[15:0] + 16'h5A00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic on, input ent_t e);
        if (m == 0) begin
            m0_cyc = on; m0_stb = on; m0_we = e.we; m0_adr = e.adr; m0_sel = e.sel;
            m0_dat_ms = e.dat; m0_cti = e.cti; m0_bte = e.bte;
        end else begin
            m1_cyc = on; m1_stb = on; m1_we = e.we; m1_adr = e.adr; m1_sel = e.sel;
            m1_dat_ms = e.dat; m1_cti = e.cti; m1_bte = e.bte;
        end
    endtask

    // Master: n back-to-back single transfers, cyc held across all of them.
    task automatic mst_run(input int m, input int n, input logic we,
                           input logic [31:0] adr0, input int step);
        ent_t e;
        int   g;
        for (int i = 0; i < n; i++) begin
            e.adr = adr0 + 32'(i * step);
            e.dat = e.adr[15:0] ^ 16'h1234;
            e.we  = we;
            e.sel = (m == 0) ? 2'b11 : 2'b01;
            e.cti = (m == 0) ? 3'b000 : 3'b010;
            e.bte = (m == 0) ? 2'b00 : 2'b01;
            drive(m, 1'b1, e);
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            g = 0;
            forever begin
                @(negedge CLK);
                if ((m == 0) ? m0_ack : m1_ack) break;
                g++;
                if (g > LIMIT) begin
                    chk("ack_timeout", 64'(m), 64'hFF);
                    drive(m, 1'b0, '0);
                    return;
                end
            end
            @(posedge CLK); #1;
        end
        drive(m, 1'b0, '0);
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        int guard = 0;
        @(negedge CLK);
        while (gnt != g && guard < LIMIT) begin
            @(negedge CLK);
            guard++;
        end
        chk("wait_gnt", gnt, g);
    endtask

    // Counts acks of the granted master from the current negedge until the
    // grant moves or stop_at acks are seen.
    task automatic cnt_acks(input logic [1:0] g, input int stop_at, output int n);
        int guard = 0;
        n = 0;
        while (gnt == g && guard < LIMIT) begin
            if ((g == 2'b01) ? m0_ack : m1_ack) n++;
            if (n >= stop_at) break;
            @(negedge CLK);
            guard++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        ack_delay = 0;
        ack_force = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        q0.delete();
        q1.delete();
        ack_cnt0 = 0;
        ack_cnt1 = 0;
        rst = 1'b0;
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge CLK);
            if (!rst && s_cyc && s_stb && s_ack) begin
                if (gnt == 2'b01) begin
                    if (q0.size() == 0) chk("sb0_empty", 64'(q0.size()), 64'd1);
                    else begin
                        e = q0.pop_front();
                        chk("bus0", {s_adr, s_sel, s_dat_ms, s_we, s_cti, s_bte}, e);
                        chk("route0", {m1_ack, m0_ack}, 2'b01);
                        if (!e.we) chk("rdat0", m0_dat_sm, e.adr[15:0] + 16'h5A00);
                    end
                end else if (gnt == 2'b10) begin
                    if (q1.size() == 0) chk("sb1_empty", 64'(q1.size()), 64'd1);
                    else begin
                        e = q1.pop_front();
                        chk("bus1", {s_adr, s_sel, s_dat_ms, s_we, s_cti, s_bte}, e);
                        chk("route1", {m1_ack, m0_ack}, 2'b10);
                        if (!e.we) chk("rdat1", m1_dat_sm, e.adr[15:0] + 16'h5A00);
                    end
                end else chk("xfer_no_gnt", gnt, 2'b01);
            end
            if (m0_ack && gnt != 2'b01) chk("m0_ack_gnt", gnt, 2'b01);
            if (m1_ack && gnt != 2'b10) chk("m1_ack_gnt", gnt, 2'b10);
            ack_cnt0 += int'(m0_ack);
            ack_cnt1 += int'(m1_ack);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_vec = 0; n_err = 0; ack_cnt0 = 0; ack_cnt1 = 0;
        ack_delay = 0; ack_force = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);

        // Reset held with both masters requesting; m0 wins on release (last=1).
        rst = 1'b1; m0_cyc = 1'b1; m1_cyc = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("rst_gnt", gnt, 2'b00);
            chk("rst_scyc", {s_cyc, s_stb}, 2'b00);
            chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
        end
        rst = 1'b0;
        @(posedge CLK); #1;
        chk("rst_first_gnt", gnt, 2'b01);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_gnt", gnt, 2'b00);
        chk("idle_bus", {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms, s_cti, s_bte}, '0);
        ack_force = 1'b1;
        @(negedge CLK);
        chk("idle_ack_ignored", {m1_ack, m0_ack}, 2'b00);
        @(posedge CLK); #1;
        ack_force = 1'b0;
        @(posedge CLK); #1;
        chk("idle_ack_no_gnt", gnt, 2'b00);

        // m1 alone: 5 writes, slave acks one cycle after stb.
        do_reset();
        ack_delay = 1;
        fork
            mst_run(1, 5, 1'b1, 32'h0, 2);
            wait_gnt(2'b10);
        join
        chk("t2_m1_acks", 64'(ack_cnt1), 64'd5);
        chk("t2_m0_acks", 64'(ack_cnt0), 64'd0);

        // m0 streams; m1 arrives on m0's first granted cycle -> 64-ack cap.
        do_reset();
        fork
            mst_run(0, 100, 1'b0, 32'h1000, 2);
            begin
                wait_gnt(2'b01);
                fork
                    mst_run(1, 10, 1'b1, 32'h8000, 2);
                    begin
                        cnt_acks(2'b01, 1000, n);
                        chk("t3_cap_acks", 64'(n), 64'd64);
                        chk("t3_switch_gnt", gnt, 2'b10);
                    end
                join
                chk("t3_m1_acks", 64'(ack_cnt1), 64'd10);
                @(negedge CLK);
                chk("t3_release_cycle", gnt, 2'b10);
                @(negedge CLK);
                chk("t3_back_gnt", gnt, 2'b01);
                chk("t3_m0_resume", m0_ack, 1'b1);
            end
        join

        // Simultaneous requests after reset: m0 first, then m1 without a bubble.
        do_reset();
        fork
            begin
                mst_run(0, 3, 1'b0, 32'h100, 2);
                @(negedge CLK);
                chk("t4_release", gnt, 2'b01);
                @(negedge CLK);
                chk("t4_no_bubble", gnt, 2'b10);
            end
            mst_run(1, 3, 1'b1, 32'h200, 2);
            begin
                n = 0;
                @(negedge CLK);
                while (gnt == 2'b00 && n < LIMIT) begin
                    @(negedge CLK);
                    n++;
                end
                chk("t4_first_gnt", gnt, 2'b01);
            end
        join

        // Slave stalls the 64th ack for 7 cycles with m1 waiting.
        do_reset();
        fork
            mst_run(0, 70, 1'b0, 32'h2000, 2);
            begin
                wait_gnt(2'b01);
                fork
                    mst_run(1, 3, 1'b1, 32'h9000, 2);
                    begin
                        cnt_acks(2'b01, 63, n);
                        chk("t5_63_acks", 64'(n), 64'd63);
                        @(posedge CLK); #1;
                        ack_delay = 7;
                        for (int i = 0; i < 7; i++) begin
                            @(negedge CLK);
                            chk("t5_hold_gnt", gnt, 2'b01);
                            chk("t5_hold_stb", s_stb, 1'b1);
                            chk("t5_no_acks", {m1_ack, m0_ack}, 2'b00);
                        end
                        @(negedge CLK);
                        chk("t5_late_ack", {gnt, m1_ack, m0_ack}, 4'b0101);
                        @(posedge CLK); #1;
                        ack_delay = 0;
                        @(negedge CLK);
                        chk("t5_switch", gnt, 2'b10);
                    end
                join
            end
        join

        // Reset pulse mid-burst in GNT1; fresh counter shows as a full 64-ack cap.
        do_reset();
        fork
            mst_run(1, 80, 1'b1, 32'h4000, 2);
            begin
                wait_gnt(2'b10);
                cnt_acks(2'b10, 3, n);
                @(posedge CLK); #1;
                rst = 1'b1;
                @(negedge CLK);
                chk("t6_ack_dropped", m1_ack, 1'b0);
                @(posedge CLK); #1;
                rst = 1'b0;
                @(negedge CLK);
                chk("t6_gnt_idle", {gnt, s_cyc}, 3'b000);
                @(negedge CLK);
                chk("t6_regrant", gnt, 2'b10);
                fork
                    mst_run(0, 5, 1'b0, 32'h6000, 2);
                    begin
                        cnt_acks(2'b10, 1000, n);
                        chk("t6_cnt_cleared", 64'(n), 64'd64);
                    end
                join
            end
        join
        chk("end_q0_empty", 64'(q0.size()), 64'd0);
        chk("end_q1_empty", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
